// File: rtl/fifo_word_packer.sv
// ---------------------------------------------------------------------------
// fifo_word_packer
//
// Read-side consumer for the byte FIFO. Pops DATA_W-bit entries through the
// FIFO's read_en/empty/data_out interface and packs them little-endian into
// DATA_W*BYTES-bit words. Words go downstream on a valid/ready handshake.
// A flush request emits the pending partial word together with its byte
// count.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_empty        FIFO empty flag
//   i_data_out     FIFO read data, valid one cycle after o_read_en
//   o_read_en      FIFO pop request
//   i_flush        single-cycle request to emit the pending partial word
//   o_word_data    packed word, byte 0 (oldest) in the lowest lane
//   o_word_bytes   number of valid bytes in o_word_data (1..BYTES)
//   o_word_valid   output word available
//   i_word_ready   downstream accepts the word
//   o_busy         assembly non-empty, read in flight, or word pending
// ---------------------------------------------------------------------------
module fifo_word_packer #(
  parameter int DATA_W = 8,
  parameter int BYTES  = 4,
  parameter int CNT_W  = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_empty,
  input  logic [DATA_W-1:0]       i_data_out,
  output logic                    o_read_en,
  input  logic                    i_flush,
  output logic [DATA_W*BYTES-1:0] o_word_data,
  output logic [CNT_W-1:0]        o_word_bytes,
  output logic                    o_word_valid,
  input  logic                    i_word_ready,
  output logic                    o_busy
);

  localparam int                 WORD_W   = DATA_W * BYTES;
  localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(BYTES);

  // Assembly register and bookkeeping
  logic [WORD_W-1:0] r_asm;
  logic [CNT_W-1:0]  r_acnt;
  logic              r_rpend;
  logic              r_fpend;

  // Output register
  logic [WORD_W-1:0] r_word;
  logic [CNT_W-1:0]  r_bytes;
  logic              r_valid;

  logic [WORD_W-1:0] w_merged;
  logic [CNT_W-1:0]  w_cntSum;
  logic              w_full;
  logic              w_outFree;
  logic              w_flushCond;
  logic              w_flushNone;
  logic              w_xfer;
  logic              w_room;

  // w_merged is the assembly with the byte that lands this cycle already
  // placed in lane r_acnt. Loading the output register from the merged view
  // lets the 4th byte go straight into the word on its capture cycle, which
  // keeps the pipeline at one byte per cycle across word boundaries.
  always_comb begin
    w_merged = r_asm;
    for (int i = 0; i < BYTES; i++) begin
      if (r_rpend && (r_acnt == CNT_W'(i))) begin
        w_merged[i*DATA_W +: DATA_W] = i_data_out;
      end
    end
  end

  // w_cntSum counts bytes held plus the byte landing this cycle; it can
  // never exceed BYTES because reads are only issued while there is room.
  assign w_cntSum    = r_acnt + {{(CNT_W-1){1'b0}}, r_rpend};
  assign w_full      = (w_cntSum == FULL_CNT);
  assign w_outFree   = !r_valid || i_word_ready;

  // A partial word is only emitted once the FIFO is dry and nothing is in
  // flight, so a flush never cuts a word short while data is still arriving.
  assign w_flushCond = r_fpend && i_empty && !r_rpend && (r_acnt != '0);
  assign w_flushNone = r_fpend && i_empty && !r_rpend && (r_acnt == '0);

  assign w_xfer      = (w_full || w_flushCond) && w_outFree;

  // On a transfer cycle the assembly empties, so a new read may be issued
  // even though the byte count looks full; otherwise a read needs a free
  // lane that is not already claimed by an in-flight byte.
  assign w_room      = w_xfer ? 1'b1 : (w_cntSum < FULL_CNT);

  // Gated by reset so no pop is requested while the block is held in reset.
  assign o_read_en   = i_rst_n && !i_empty && w_room;

  assign o_word_data  = r_word;
  assign o_word_bytes = r_bytes;
  assign o_word_valid = r_valid;
  assign o_busy       = (r_acnt != '0) || r_rpend || r_valid;

  // Datapath and control state. A transfer moves the merged assembly into the
  // output register and restarts assembly at lane 0; without a transfer the
  // landing byte is folded into the assembly and the output register only
  // drops valid once its word is accepted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_asm   <= '0;
      r_acnt  <= '0;
      r_rpend <= 1'b0;
      r_fpend <= 1'b0;
      r_word  <= '0;
      r_bytes <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_word  <= w_merged;
        r_bytes <= w_cntSum;
        r_valid <= 1'b1;
        r_asm   <= '0;
        r_acnt  <= '0;
      end else begin
        if (r_valid && i_word_ready) begin
          r_valid <= 1'b0;
        end
        if (r_rpend) begin
          r_asm  <= w_merged;
          r_acnt <= w_cntSum;
        end
      end

      r_rpend <= o_read_en;

      // A new request always wins; otherwise the pending flush retires when
      // its partial word is handed over or when there turns out to be
      // nothing to flush.
      if (i_flush) begin
        r_fpend <= 1'b1;
      end else if ((w_flushCond && w_outFree) || w_flushNone) begin
        r_fpend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// ---------------------------------------------------------------------------
// tb_fifo_word_packer
//
// Directed testbench for fifo_word_packer. A small FIFO model feeds bytes
// with one-cycle read latency; accepted words are logged and compared with
// hand-computed values.
// ---------------------------------------------------------------------------
module tb_fifo_word_packer;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        fifoEmpty;
  logic [7:0]  dataOut = '0;
  logic        readEn;
  logic        flush = 1'b0;
  logic [31:0] wordData;
  logic [2:0]  wordBytes;
  logic        wordValid;
  logic        wordReady = 1'b1;
  logic        busy;

  logic [7:0]  fifoMem [0:63];
  int          wrPtr = 0;
  int          rdPtr = 0;
  logic        gateEmpty = 1'b0;

  logic [31:0] logWord  [0:31];
  logic [2:0]  logBytes [0:31];
  int          logCount = 0;

  int          checks = 0;
  int          errors = 0;
  int          emptyViolations = 0;

  int          base;
  int          readCount;
  logic [31:0] reHist;
  logic        sawValid;

  fifo_word_packer #(
    .DATA_W(8),
    .BYTES (4),
    .CNT_W (3)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .i_empty      (fifoEmpty),
    .i_data_out   (dataOut),
    .o_read_en    (readEn),
    .i_flush      (flush),
    .o_word_data  (wordData),
    .o_word_bytes (wordBytes),
    .o_word_valid (wordValid),
    .i_word_ready (wordReady),
    .o_busy       (busy)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // The FIFO reports empty when drained or when the bench forces a bubble.
  assign fifoEmpty = (wrPtr == rdPtr) || gateEmpty;

  // FIFO read port: a pop on this edge presents its data for the next cycle.
  always @(posedge clk) begin
    if (readEn) begin
      dataOut <= fifoMem[rdPtr[5:0]];
      rdPtr   <= rdPtr + 1;
    end
  end

  // Record every word the sink accepts so it can be checked afterwards.
  always @(posedge clk) begin
    if (rstN && wordValid && wordReady) begin
      logWord[logCount[4:0]]  <= wordData;
      logBytes[logCount[4:0]] <= wordBytes;
      logCount                <= logCount + 1;
    end
  end

  // Watch for a pop request while the FIFO claims to be empty.
  always @(negedge clk) begin
    if (rstN && readEn && fifoEmpty) begin
      emptyViolations <= emptyViolations + 1;
    end
  end

  task automatic pushByte(input logic [7:0] b);
    fifoMem[wrPtr[5:0]] = b;
    wrPtr = wrPtr + 1;
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic pulseFlush();
    flush = 1'b1;
    #1;
    applyStimulus();
    flush = 1'b0;
  endtask

  // Directed sequence covering streaming, back-pressure, flush, reset and
  // a bursty FIFO.
  initial begin
    // Reset state with the FIFO already holding data
    for (int i = 1; i <= 8; i++) pushByte(8'(i * 8'h11));
    applyStimulus();
    applyStimulus();
    #1;
    checkOutput("reset read_en", readEn, 32'h0);
    checkOutput("reset word_valid", wordValid, 32'h0);
    checkOutput("reset word_data", wordData, 32'h0);
    checkOutput("reset word_bytes", wordBytes, 32'h0);
    checkOutput("reset busy", busy, 32'h0);

    // Streaming with the sink always ready
    $display("[TB] streaming two words");
    base = logCount;
    reHist = '0;
    rstN = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      #1;
      if (readEn) reHist[k] = 1'b1;
      if (k == 4) checkOutput("t1 valid before latency", wordValid, 32'h0);
      if (k == 5) begin
        checkOutput("t1 first word valid", wordValid, 32'h1);
        checkOutput("t1 first word data", wordData, 32'h44332211);
        checkOutput("t1 first word bytes", wordBytes, 32'h4);
      end
      if (k == 6) checkOutput("t1 valid drops", wordValid, 32'h0);
      if (k == 9) checkOutput("t1 second word data", wordData, 32'h88776655);
      if (k == 10) begin
        checkOutput("t1 idle valid", wordValid, 32'h0);
        checkOutput("t1 idle busy", busy, 32'h0);
      end
      applyStimulus();
    end
    checkOutput("t1 read_en pattern", reHist, 32'h000000FF);
    checkOutput("t1 word count", logCount - base, 32'h2);
    checkOutput("t1 log word0", logWord[base], 32'h44332211);
    checkOutput("t1 log word1", logWord[base+1], 32'h88776655);
    checkOutput("t1 log bytes1", logBytes[base+1], 32'h4);

    // Back-pressure: sink not ready for the first 15 cycles
    $display("[TB] back-pressure");
    base = logCount;
    readCount = 0;
    for (int i = 1; i <= 8; i++) pushByte(8'(i * 8'h11));
    for (int k = 0; k <= 17; k++) begin
      wordReady = (k >= 15);
      #1;
      if (readEn) readCount++;
      if (k >= 5 && k <= 14) begin
        checkOutput("t2 hold valid", wordValid, 32'h1);
        checkOutput("t2 hold data", wordData, 32'h44332211);
      end
      if (k == 14) begin
        checkOutput("t2 pops during stall", readCount, 32'h8);
        checkOutput("t2 busy during stall", busy, 32'h1);
      end
      if (k == 15) checkOutput("t2 release data", wordData, 32'h44332211);
      if (k == 16) begin
        checkOutput("t2 second valid", wordValid, 32'h1);
        checkOutput("t2 second data", wordData, 32'h88776655);
        checkOutput("t2 second bytes", wordBytes, 32'h4);
      end
      if (k == 17) begin
        checkOutput("t2 idle valid", wordValid, 32'h0);
        checkOutput("t2 idle busy", busy, 32'h0);
      end
      applyStimulus();
    end
    checkOutput("t2 word count", logCount - base, 32'h2);

    // Flush of a three-byte partial word
    $display("[TB] partial flush");
    base = logCount;
    pushByte(8'hA1);
    pushByte(8'hB2);
    pushByte(8'hC3);
    for (int k = 0; k < 6; k++) applyStimulus();
    checkOutput("t3 no word before flush", wordValid, 32'h0);
    checkOutput("t3 busy before flush", busy, 32'h1);
    pulseFlush();
    for (int k = 0; k < 6; k++) applyStimulus();
    checkOutput("t3 word count", logCount - base, 32'h1);
    checkOutput("t3 partial data", logWord[base], 32'h00C3B2A1);
    checkOutput("t3 partial bytes", logBytes[base], 32'h3);
    checkOutput("t3 busy after", busy, 32'h0);

    // Flush with nothing pending, then confirm the request did not linger
    $display("[TB] empty flush");
    base = logCount;
    sawValid = 1'b0;
    pulseFlush();
    for (int k = 0; k < 4; k++) begin
      if (wordValid) sawValid = 1'b1;
      applyStimulus();
    end
    checkOutput("t4 no word on empty flush", sawValid, 32'h0);
    checkOutput("t4 busy after empty flush", busy, 32'h0);
    pushByte(8'h5A);
    pushByte(8'hA5);
    for (int k = 0; k < 8; k++) begin
      if (wordValid) sawValid = 1'b1;
      applyStimulus();
    end
    checkOutput("t4 stale flush emitted word", sawValid, 32'h0);
    checkOutput("t4 holding partial", busy, 32'h1);
    pulseFlush();
    for (int k = 0; k < 6; k++) applyStimulus();
    checkOutput("t4 word count", logCount - base, 32'h1);
    checkOutput("t4 partial data", logWord[base], 32'h0000A55A);
    checkOutput("t4 partial bytes", logBytes[base], 32'h2);

    // Asynchronous reset after two bytes have been captured
    $display("[TB] mid-assembly reset");
    base = logCount;
    pushByte(8'hDE);
    pushByte(8'hAD);
    for (int k = 0; k < 3; k++) applyStimulus();
    checkOutput("t5 busy before reset", busy, 32'h1);
    rstN = 1'b0;
    #1;
    checkOutput("t5 reset read_en", readEn, 32'h0);
    checkOutput("t5 reset valid", wordValid, 32'h0);
    checkOutput("t5 reset data", wordData, 32'h0);
    checkOutput("t5 reset bytes", wordBytes, 32'h0);
    checkOutput("t5 reset busy", busy, 32'h0);
    applyStimulus();
    wrPtr = rdPtr;
    rstN = 1'b1;
    pushByte(8'h10);
    pushByte(8'h20);
    pushByte(8'h30);
    pushByte(8'h40);
    for (int k = 0; k < 8; k++) applyStimulus();
    checkOutput("t5 word count", logCount - base, 32'h1);
    checkOutput("t5 clean word", logWord[base], 32'h40302010);
    checkOutput("t5 clean bytes", logBytes[base], 32'h4);

    // Bursty FIFO: empty toggles every cycle, six bytes, then flush
    $display("[TB] bursty source");
    base = logCount;
    for (int i = 1; i <= 6; i++) pushByte(8'(8'h60 + i));
    for (int k = 0; k < 20; k++) begin
      gateEmpty = (k % 2 == 1);
      applyStimulus();
    end
    gateEmpty = 1'b0;
    for (int k = 0; k < 3; k++) applyStimulus();
    pulseFlush();
    for (int k = 0; k < 6; k++) applyStimulus();
    checkOutput("t6 word count", logCount - base, 32'h2);
    checkOutput("t6 full word", logWord[base], 32'h64636261);
    checkOutput("t6 full bytes", logBytes[base], 32'h4);
    checkOutput("t6 tail word", logWord[base+1], 32'h00006665);
    checkOutput("t6 tail bytes", logBytes[base+1], 32'h2);
    checkOutput("t6 busy after", busy, 32'h0);
    checkOutput("read_en while empty", emptyViolations, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
